mem_arb: RTL

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb_if.sv | 51 +++++
 rtl/mem_arb_age.sv | 29 ++
 rtl/mem_arb.sv | 101 ++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port RAM arbiter.
// Holds the response FSM state encoding and the age counter width.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;
    localparam int AGE_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        RESP_I,
        RESP_D
    } resp_state_e;

endpackage

// File: rtl/mem_arb_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the RAM.
// slave: arbiter view (requests in, grants/responses/RAM strobes out).
// master: requester + RAM view (the mirror image).
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    localparam int BE_W = DATA_W / 8;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [BE_W-1:0]   d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_read;
    logic [BE_W-1:0]   ram_write;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output ram_addr, ram_read, ram_write, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  ram_addr, ram_read, ram_write, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/mem_arb_age.sv
// Fetch starvation counter: counts cycles fetch waits, saturating at 15.
// Ports: clk, rst_n, i_req, i_gnt in; age_hit out (count >= MAX_WAIT).
module mem_arb_age
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic i_gnt,
    output logic age_hit
);

    logic [AGE_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (i_gnt) begin
            cnt_q <= '0;
        end else if (i_req && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign age_hit = (cnt_q >= AGE_CNT_W'(MAX_WAIT));

endmodule

// File: rtl/mem_arb.sv
// Arbiter sharing one single-port RAM between a fetch and a data port.
// Ports: clk, rst_n, bus (mem_arb_if.slave). Define MEM_ARB_AGE_EN for fetch anti-starvation.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 4
) (
    input logic     clk,
    input logic     rst_n,
    mem_arb_if.slave bus
);

    localparam int BE_W = DATA_W / 8;

    if ((MAX_WAIT < 1) || (MAX_WAIT > 15)) begin : g_bad_wait
        $error("mem_arb: MAX_WAIT out of range 1..15");
    end

    resp_state_e       state_q;
    resp_state_e       state_d;
    logic              i_gnt;
    logic              d_gnt;
    logic              age_hit;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_read;
    logic [BE_W-1:0]   ram_write;
    logic [DATA_W-1:0] ram_wdata;

`ifdef MEM_ARB_AGE_EN
    mem_arb_age #(
        .MAX_WAIT (MAX_WAIT)
    ) u_age (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (bus.i_req),
        .i_gnt   (i_gnt),
        .age_hit (age_hit)
    );
`else
    assign age_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grants are gated by rst_n so nothing reaches the RAM during reset.
    always_comb begin
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        ram_addr  = '0;
        ram_read  = 1'b0;
        ram_write = '0;
        ram_wdata = '0;
        state_d   = IDLE;
        if (rst_n) begin
            if (bus.d_req && !(bus.i_req && age_hit)) begin
                d_gnt = 1'b1;
            end else if (bus.i_req) begin
                i_gnt = 1'b1;
            end
        end
        unique case (1'b1)
            d_gnt: begin
                ram_addr = bus.d_addr;
                if (bus.d_we) begin
                    ram_write = bus.d_be;
                    ram_wdata = bus.d_wdata;
                end else begin
                    ram_read = 1'b1;
                    state_d  = RESP_D;
                end
            end
            i_gnt: begin
                ram_addr = bus.i_addr;
                ram_read = 1'b1;
                state_d  = RESP_I;
            end
            default: ;
        endcase
    end

    assign bus.i_gnt     = i_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.ram_addr  = ram_addr;
    assign bus.ram_read  = ram_read;
    assign bus.ram_write = ram_write;
    assign bus.ram_wdata = ram_wdata;

    assign bus.i_rvalid = (state_q == RESP_I);
    assign bus.d_rvalid = (state_q == RESP_D);
    assign bus.i_rdata  = bus.i_rvalid ? bus.ram_rdata : '0;
    assign bus.d_rdata  = bus.d_rvalid ? bus.ram_rdata : '0;

endmodule
